// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock-enable pixel divider, h/v counters, sync/bright decodes, frame tick.
// Optional `VGA_FRAME_CNT_EN adds an 8-bit frame counter output (frame_cnt).
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL  = 525
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    localparam logic [9:0] HSyncEnd = 10'(H_SYNC);
    localparam logic [9:0] HActBeg  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] HActEnd  = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
    localparam logic [9:0] VSyncEnd = 10'(V_SYNC);
    localparam logic [9:0] VActBeg  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] VActEnd  = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [9:0]      h_q, h_d;
    logic [9:0]      v_q, v_d;
    logic            h_wrap, v_wrap;

    // With CLK_DIV == 1 the divider never leaves 0, so pix_tick stays high.
    assign pix_tick = (div_q == DivMax);
    assign h_wrap   = (h_q == HLast);
    assign v_wrap   = (v_q == VLast);

    always_comb begin
        div_d = pix_tick ? '0 : div_q + DivW'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (pix_tick) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign hCount     = h_q;
    assign vCount     = v_q;
    assign hSync      = (h_q >= HSyncEnd);
    assign vSync      = (v_q >= VSyncEnd);
    assign bright     = (h_q >= HActBeg) && (h_q < HActEnd) &&
                        (v_q >= VActBeg) && (v_q < VActEnd);
    assign frame_tick = pix_tick && h_wrap && v_wrap;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_q, fc_d;

    always_comb begin
        fc_d = frame_tick ? fc_q + 8'd1 : fc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign frame_cnt = fc_q;
`endif

endmodule
